muldiv_unit: RTL and testbench

- Multi-cycle RV64M execute unit. It consumes the two register-file read operands (ReadData1/ReadData2) and produces a 64-bit value for the register-file WriteData/RD/RegWrite path.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a shift-add multiplier and a restoring divider, one bit per cycle.
- The pipeline stalls on busy and writes back on done.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_negate.sv | 16 +
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the RV64M multiply/divide execute unit:
//   funct3 encodings, the control FSM state encoding and the default width.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 64;

    // RV M-extension funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } stateT;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic isSignedA(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic isSignedB(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/response bundle between the issue stage and the mul/div unit.
//   master : issue stage   (drives start/kill/funct3/op_a/op_b/rd_in)
//   slave  : muldiv_unit   (drives busy/done/result/rd_out)
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_negate.sv
// -----------------------------------------------------------------------------
// muldiv_negate
//   Combinational conditional two's-complement.
//   in  : value to negate
//   en  : 1 = output -in, 0 = output in unchanged
//   out : result
// -----------------------------------------------------------------------------
module muldiv_negate #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out
);
    assign out = en ? (~in + WIDTH'(1)) : in;
endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RV64M execute unit: MUL/MULH/MULHSU/MULHU via shift-add and
//   DIV/DIVU/REM/REMU via restoring division, one bit per cycle on operand
//   magnitudes, with sign fixup at the end.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : slave side of muldiv_unit_if (start/kill/funct3/op_a/op_b/rd_in in,
//           busy/done/result/rd_out out)
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 7
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    stateT            state;
    logic [2:0]       f3Reg;
    logic [4:0]       rdReg;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  hi;       // MUL: accumulator upper half; DIV: remainder
    logic [XLEN-1:0]  lo;       // MUL: multiplier / product low; DIV: quotient
    logic [XLEN-1:0]  bReg;     // multiplicand or divisor magnitude
    logic             negRes;
    logic             negRem;
    logic             busyReg;
    logic             doneReg;
    logic [XLEN-1:0]  resultReg;

    // ---------------- request decode (IDLE) ----------------
    logic            aNeg, bNeg, isRemIn, divZero, overflow;
    logic [XLEN-1:0] absA, absB;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        aNeg     = isSignedA(bus.funct3) & bus.op_a[XLEN-1];
        bNeg     = isSignedB(bus.funct3) & bus.op_b[XLEN-1];
        isRemIn  = bus.funct3[2] & bus.funct3[1];
        divZero  = bus.funct3[2] && (bus.op_b == '0);
        overflow = isSignedB(bus.funct3) && bus.funct3[2]
                   && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    end

    muldiv_negate #(.WIDTH(XLEN)) uAbsA (.in(bus.op_a), .en(aNeg), .out(absA));
    muldiv_negate #(.WIDTH(XLEN)) uAbsB (.in(bus.op_b), .en(bNeg), .out(absB));

    // ---------------- one iteration (CALC) ----------------
    logic            isMul, isRem;
    logic [XLEN:0]   mulSum, divShift, divDiff;
    logic [XLEN-1:0] hiNext, loNext;

    always_comb begin
        isMul    = ~f3Reg[2];
        isRem    = f3Reg[2] & f3Reg[1];
        mulSum   = {1'b0, hi} + {1'b0, bReg};
        divShift = {hi, lo[XLEN-1]};
        divDiff  = divShift - {1'b0, bReg};
        hiNext   = hi;
        loNext   = lo;
        if (isMul) begin
            // Add into the upper half (keeping the carry), then shift the whole
            // 2*XLEN accumulator right so the next multiplier bit reaches lo[0].
            if (lo[0]) begin
                hiNext = mulSum[XLEN:1];
                loNext = {mulSum[0], lo[XLEN-1:1]};
            end else begin
                hiNext = {1'b0, hi[XLEN-1:1]};
                loNext = {hi[0], lo[XLEN-1:1]};
            end
        end else begin
            // Top bit of the XLEN+1 difference is the borrow: set means rem < divisor.
            if (!divDiff[XLEN]) begin
                hiNext = divDiff[XLEN-1:0];
                loNext = {lo[XLEN-2:0], 1'b1};
            end else begin
                hiNext = divShift[XLEN-1:0];
                loNext = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // ---------------- result selection (FIXUP) ----------------
    // Negating the full 2*XLEN product is required: MULH's high half depends
    // on the borrow out of the low half.
    logic [2*XLEN-1:0] fixIn, fixOut;
    logic              fixEn;
    logic [XLEN-1:0]   fixSel;

    always_comb begin
        fixIn = isMul ? {hi, lo} : {{XLEN{1'b0}}, (isRem ? hi : lo)};
        fixEn = isRem ? negRem : negRes;
    end

    muldiv_negate #(.WIDTH(2*XLEN)) uFix (.in(fixIn), .en(fixEn), .out(fixOut));

    always_comb begin
        if (isMul && (f3Reg != F3_MUL)) fixSel = fixOut[2*XLEN-1:XLEN];
        else                            fixSel = fixOut[XLEN-1:0];
    end

    // ---------------- control FSM + datapath registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too (not just control), so a
        // reset mid-operation leaves no stale operand or partial product behind.
        if (!reset) begin
            state     <= IDLE;
            f3Reg     <= '0;
            rdReg     <= '0;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            bReg      <= '0;
            negRes    <= 1'b0;
            negRem    <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            resultReg <= '0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.kill) begin
                        f3Reg   <= bus.funct3;
                        rdReg   <= bus.rd_in;
                        count   <= '0;
                        bReg    <= absB;
                        negRem  <= isRemIn & aNeg;
                        busyReg <= 1'b1;
                        // Special cases preload hi/lo so FIXUP's ordinary
                        // selection yields the architectural result.
                        if (divZero) begin
                            lo     <= '1;          // quotient = all ones
                            hi     <= absA;        // remainder = op_a after sign fixup
                            negRes <= 1'b0;
                            state  <= FIXUP;
                        end else begin
                            lo     <= absA;        // overflow: quotient = |MIN| = MIN
                            hi     <= '0;          // overflow: remainder = 0
                            negRes <= aNeg ^ bNeg;
                            state  <= overflow ? FIXUP : CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        hi    <= hiNext;
                        lo    <= loNext;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(XLEN-1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (bus.kill) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        resultReg <= fixSel;
                        doneReg   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
    assign bus.result = resultReg;
    assign bus.rd_out = rdReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed and random checks of muldiv_unit against an arithmetic reference
//   model built from the RV64M result rules.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [63:0] lastResult = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refModel(input logic [2:0] f, input logic [63:0] a,
                                             input logic [63:0] b);
        logic [127:0] sa, za, sb, zb, p;
        longint       la, lb;
        sa = {{64{a[63]}}, a}; za = {64'd0, a};
        sb = {{64{b[63]}}, b}; zb = {64'd0, b};
        la = a; lb = b;
        case (f)
            F3_MUL:    begin p = za * zb; return p[63:0];   end
            F3_MULH:   begin p = sa * sb; return p[127:64]; end
            F3_MULHSU: begin p = sa * zb; return p[127:64]; end
            F3_MULHU:  begin p = za * zb; return p[127:64]; end
            F3_DIV:    if (b == 0) return '1;
                       else if (a == MINV && b == '1) return a;
                       else return 64'(la / lb);
            F3_DIVU:   return (b == 0) ? '1 : a / b;
            F3_REM:    if (b == 0) return a;
                       else if (a == MINV && b == '1) return '0;
                       else return 64'(la % lb);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == F3_DIV || f == F3_REM) && a == MINV && b == '1;
    endfunction

    // Caller is at a negedge. Start is driven now; cycles are counted as the
    // negedges that follow until done is seen.
    task automatic runOp(input string tag, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        int          n;
        bit          seen;
        logic [63:0] exp;
        int          expLat;
        exp    = refModel(f, a, b);
        expLat = isSpecial(f, a, b) ? 2 : XLEN + 2;
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1;
        end
        check($sformatf("%s.latency", tag), 64'(n), 64'(expLat));
        check($sformatf("%s.result", tag), bus.result, exp);
        check($sformatf("%s.rd_out", tag), 64'(bus.rd_out), 64'(rd));
        @(negedge clk);
        check($sformatf("%s.donePulse", tag), 64'(bus.done), 64'd0);
        check($sformatf("%s.busyAfter", tag), 64'(bus.busy), 64'd0);
        lastResult = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          doneCnt;
        int          doneAt;
        logic [63:0] a, b, exp;
        logic [2:0]  f;

        // 1. reset held with start asserted
        reset = 1'b0; bus.start = 1'b1; bus.kill = 1'b0; bus.funct3 = F3_MUL;
        bus.op_a = 64'd7; bus.op_b = 64'd6; bus.rd_in = 5'd3;
        repeat (2) @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.result", bus.result, 64'd0);
        check("rst.rd_out", 64'(bus.rd_out), 64'd0);
        reset = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        check("rst.idleBusy", 64'(bus.busy), 64'd0);
        runOp("mul7x6", F3_MUL, 64'd7, 64'd6, 5'd20);
        check("mul7x6.value", bus.result, 64'd42);

        // 2. high-half multiplies
        runOp("mulh", F3_MULH, '1, '1, 5'd1);
        runOp("mulhu", F3_MULHU, '1, '1, 5'd2);
        runOp("mulhsu", F3_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd3);

        // 3. signed/unsigned divide and remainder
        runOp("div", F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
        runOp("rem", F3_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5);
        runOp("divu", F3_DIVU, 64'd100, 64'd7, 5'd6);
        runOp("remu", F3_REMU, 64'd100, 64'd7, 5'd7);

        // 4. divide by zero and signed overflow
        runOp("divu0", F3_DIVU, 64'd5, 64'd0, 5'd8);
        runOp("rem0", F3_REM, 64'd5, 64'd0, 5'd9);
        runOp("divOvf", F3_DIV, MINV, '1, 5'd10);
        runOp("remOvf", F3_REM, MINV, '1, 5'd11);

        // 5. kill mid-divide, then restart the very next cycle
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = 64'd100; bus.op_b = 64'd7; bus.rd_in = 5'd12;
        doneCnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) doneCnt++;
        end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        if (bus.done === 1'b1) doneCnt++;
        check("kill.busy", 64'(bus.busy), 64'd0);
        check("kill.noDone", 64'(doneCnt), 64'd0);
        check("kill.resultHeld", bus.result, lastResult);
        runOp("afterKill", F3_DIV, 64'd100, 64'd7, 5'd13);

        // 6a. starts while busy are ignored
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        exp = refModel(F3_MULHU, a, b);
        bus.start = 1'b1; bus.funct3 = F3_MULHU; bus.op_a = a; bus.op_b = b; bus.rd_in = 5'd14;
        doneCnt = 0; doneAt = 0;
        for (n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 10 || n == 40) begin
                bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.op_a = 64'd9; bus.op_b = 64'd3; bus.rd_in = 5'd15;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                doneCnt++;
                if (doneAt == 0) doneAt = n;
            end
        end
        check("ignore.doneCount", 64'(doneCnt), 64'd1);
        check("ignore.doneAt", 64'(doneAt), 64'(XLEN + 2));
        check("ignore.result", bus.result, exp);
        check("ignore.rd_out", 64'(bus.rd_out), 64'd14);
        lastResult = exp;

        // 6b. reset in the middle of an operation
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = {$urandom, $urandom}; bus.op_b = 64'd3; bus.rd_in = 5'd16;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        check("midRst.busy", 64'(bus.busy), 64'd0);
        check("midRst.done", 64'(bus.done), 64'd0);
        check("midRst.result", bus.result, 64'd0);
        check("midRst.rd_out", 64'(bus.rd_out), 64'd0);
        reset = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCnt++;
        end
        check("midRst.noDone", 64'(doneCnt), 64'd0);
        lastResult = '0;

        // 7. random operations, with operand corner cases mixed in
        for (int i = 0; i < 32; i++) begin
            f = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MINV; b = '1; end
                2: b = 64'($urandom_range(1, 1000));
                3: a = 64'($urandom_range(0, 1000));
                4: b = {{32{b[31]}}, b[31:0]};
                default: ;
            endcase
            runOp($sformatf("rnd%0d_f%0d", i, f), f, a, b, 5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
